// File: rtl/i2c_pkg.sv
// Shared types and widths for the I2C transaction arbiter and its I2C_Master
// command/status bus.
package i2c_pkg;

    localparam int unsigned TIMEOUT_CYC_DEF = 200000;
    localparam int unsigned NBYTE_W         = 6;
    localparam int unsigned DEV_W           = 7;
    localparam int unsigned PTR_W           = 8;
    localparam int unsigned DATA_W          = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_BUSY,
        ST_FINISH,
        ST_FAULT
    } state_t;

endpackage

// File: rtl/i2c_txn_arbiter_if.sv
// Command/status bus between the transaction arbiter (master side) and the
// I2C_Master engine (slave side).
interface i2c_txn_arbiter_if;
    import i2c_pkg::*;

    logic                go;
    logic                rw;
    logic [NBYTE_W-1:0]  N_Byte;
    logic [DEV_W-1:0]    dev_add;
    logic [PTR_W-1:0]    R_Pointer;
    logic [DATA_W-1:0]   dwr_DataWriteReg;
    logic                done;
    logic                ready;
    logic                ack_e;
    logic [DATA_W-1:0]   drd_lcdData;

    modport master (
        output go, rw, N_Byte, dev_add, R_Pointer, dwr_DataWriteReg,
        input  done, ready, ack_e, drd_lcdData
    );

    modport slave (
        input  go, rw, N_Byte, dev_add, R_Pointer, dwr_DataWriteReg,
        output done, ready, ack_e, drd_lcdData
    );

endinterface

// File: rtl/rr_pick2.sv
// Two-way round-robin winner select: rr_ptr breaks a tie, a lone requester
// always wins, no request gives no winner.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       rr_ptr,
    output logic [1:0] win
);

    always_comb begin
        win = '0;
        case (req)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            2'b11:   win = rr_ptr ? 2'b10 : 2'b01;
            default: win = '0;
        endcase
    end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Arbitrates two requesters onto one I2C_Master: round-robin grant, one go
// pulse per transaction, completion/error pulses and a BUSY watchdog.
module i2c_txn_arbiter
    import i2c_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int unsigned NREQ        = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          req_rw,
    input  logic [NREQ*NBYTE_W-1:0]  req_nbyte,
    input  logic [NREQ*DEV_W-1:0]    req_dev,
    input  logic [NREQ*PTR_W-1:0]    req_ptr,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          cmp,
    output logic [NREQ-1:0]          err,
    output logic [NREQ-1:0]          byte_ack,
    output logic [DATA_W-1:0]        rdata,
    output logic                     busy,
    i2c_txn_arbiter_if.master        i2c
);

    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC);

    state_t              state;
    state_t              state_nx;
    logic [1:0]          win;
    logic                rr_ptr;
    logic [WD_W-1:0]     wd;
    logic                go;
    logic                rw_r;
    logic [NBYTE_W-1:0]  nbyte_r;
    logic [DEV_W-1:0]    dev_r;
    logic [PTR_W-1:0]    ptr_r;

    rr_pick2 u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .win    (win)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        go       = 1'b0;
        cmp      = '0;
        err      = '0;
        byte_ack = '0;
        busy     = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (i2c.ready && (|req)) state_nx = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                if (nbyte_r == '0) begin
                    state_nx = ST_FAULT;
                end else begin
                    go       = 1'b1;
                    state_nx = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (i2c.ack_e) byte_ack = gnt;
                // done takes priority over a coincident watchdog expiry
                if (i2c.done)                               state_nx = ST_FINISH;
                else if (wd == WD_W'(TIMEOUT_CYC - 1))      state_nx = ST_FAULT;
            end
            ST_FINISH: begin
                cmp      = gnt;
                state_nx = ST_IDLE;
            end
            ST_FAULT: begin
                err      = gnt;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt     <= '0;
            rr_ptr  <= 1'b0;
            wd      <= '0;
            rw_r    <= 1'b0;
            nbyte_r <= '0;
            dev_r   <= '0;
            ptr_r   <= '0;
            rdata   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (state_nx == ST_LAUNCH) begin
                        gnt     <= win;
                        rw_r    <= win[1] ? req_rw[1] : req_rw[0];
                        nbyte_r <= win[1] ? req_nbyte[2*NBYTE_W-1:NBYTE_W] : req_nbyte[NBYTE_W-1:0];
                        dev_r   <= win[1] ? req_dev[2*DEV_W-1:DEV_W]       : req_dev[DEV_W-1:0];
                        ptr_r   <= win[1] ? req_ptr[2*PTR_W-1:PTR_W]       : req_ptr[PTR_W-1:0];
                    end
                end
                ST_LAUNCH: wd <= '0;
                ST_BUSY: begin
                    if (wd != '1) wd <= wd + 1'b1;
                    if (i2c.ack_e && rw_r) rdata <= i2c.drd_lcdData;
                end
                ST_FINISH, ST_FAULT: begin
                    gnt    <= '0;
                    rr_ptr <= ~gnt[1];
                end
                default: ;
            endcase
        end
    end

    assign i2c.go               = go;
    assign i2c.rw               = rw_r;
    assign i2c.N_Byte           = nbyte_r;
    assign i2c.dev_add          = dev_r;
    assign i2c.R_Pointer        = ptr_r;
    // live mux so a requester can present its next byte after each byte_ack
    assign i2c.dwr_DataWriteReg = gnt[1] ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Directed self-checking bench: one arbiter with a long watchdog for the
// transaction tests, one with TIMEOUT_CYC=16 for the watchdog tests.
module tb_i2c_txn_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [1:0]  req_rw;
    logic [11:0] req_nbyte;
    logic [13:0] req_dev;
    logic [15:0] req_ptr;
    logic [15:0] req_wdata;

    logic [1:0]  gnt, cmp, err, byte_ack;
    logic [7:0]  rdata;
    logic        busy;
    logic [1:0]  gnt16, cmp16, err16, back16;
    logic [7:0]  rdata16;
    logic        busy16;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;
    int unsigned go_cnt = 0;
    int unsigned cmp_cnt = 0;
    int unsigned err_cnt = 0;
    logic        both_seen = 1'b0;
    int unsigned snap_go, snap_cmp, snap_err;

    i2c_txn_arbiter_if bus ();
    i2c_txn_arbiter_if bus16 ();

    assign bus16.done        = bus.done;
    assign bus16.ready       = bus.ready;
    assign bus16.ack_e       = bus.ack_e;
    assign bus16.drd_lcdData = bus.drd_lcdData;

    always #5 clk = ~clk;

    i2c_txn_arbiter #(.TIMEOUT_CYC(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_rw    (req_rw),
        .req_nbyte (req_nbyte),
        .req_dev   (req_dev),
        .req_ptr   (req_ptr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .cmp       (cmp),
        .err       (err),
        .byte_ack  (byte_ack),
        .rdata     (rdata),
        .busy      (busy),
        .i2c       (bus)
    );

    i2c_txn_arbiter #(.TIMEOUT_CYC(16)) dut16 (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_rw    (req_rw),
        .req_nbyte (req_nbyte),
        .req_dev   (req_dev),
        .req_ptr   (req_ptr),
        .req_wdata (req_wdata),
        .gnt       (gnt16),
        .cmp       (cmp16),
        .err       (err16),
        .byte_ack  (back16),
        .rdata     (rdata16),
        .busy      (busy16),
        .i2c       (bus16)
    );

    always @(negedge clk) begin
        if (bus.go) go_cnt++;
        if (cmp != '0) cmp_cnt++;
        if (err != '0) err_cnt++;
        if ((cmp != '0) && (err != '0)) both_seen = 1'b1;
        if ((cmp16 != '0) && (err16 != '0)) both_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        else             n_pass++;
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    // Entered at a negedge while in BUSY; leaves at the negedge back in IDLE.
    task automatic finish_busy(input string tag, input logic [1:0] exp_g);
        bus.done = 1'b1;
        tick(1);
        check({tag, "_cmp"}, cmp, exp_g);
        check({tag, "_err"}, err, 2'b00);
        bus.done = 1'b0;
        tick(1);
        check({tag, "_gnt_rel"}, gnt, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        req = '0; req_rw = '0; req_nbyte = '0; req_dev = '0; req_ptr = '0; req_wdata = '0;
        bus.done = 1'b0; bus.ready = 1'b1; bus.ack_e = 1'b0; bus.drd_lcdData = '0;

        tick(2);
        check("rst_gnt", gnt, 2'b00);
        check("rst_busy", busy, 1'b0);
        check("rst_go", bus.go, 1'b0);
        check("rst_nbyte", bus.N_Byte, 6'd0);
        check("rst_rdata", rdata, 8'h00);
        reset = 1'b0;

        // Single write from requester 0
        req_nbyte[5:0] = 6'd2; req_dev[6:0] = 7'h48; req_ptr[7:0] = 8'h01;
        req_wdata[7:0] = 8'h55; req = 2'b01;
        tick(1);
        check("wr_gnt", gnt, 2'b01);
        check("wr_go", bus.go, 1'b1);
        check("wr_dev", bus.dev_add, 7'h48);
        check("wr_nbyte", bus.N_Byte, 6'd2);
        check("wr_ptr", bus.R_Pointer, 8'h01);
        check("wr_wdata", bus.dwr_DataWriteReg, 8'h55);
        req = 2'b00;
        tick(1);
        check("wr_go_one_cycle", bus.go, 1'b0);
        check("wr_gnt_hold", gnt, 2'b01);
        bus.ack_e = 1'b1; bus.drd_lcdData = 8'h99;
        #1 check("wr_back", byte_ack, 2'b01);
        tick(1);
        bus.ack_e = 1'b0;
        check("wr_no_rcap", rdata, 8'h00);
        req_wdata[7:0] = 8'h66;
        #1 check("wr_wdata_live", bus.dwr_DataWriteReg, 8'h66);
        tick(46);
        check("wr_fields_held", bus.dev_add, 7'h48);
        finish_busy("wr", 2'b01);
        check("wr_busy_idle", busy, 1'b0);
        check("wr_go_count", go_cnt, 1);

        // Contention: round-robin order 0,1,0 then 1 after a fresh 11
        do_reset();
        req_nbyte = {6'd1, 6'd1}; req_dev = {7'h22, 7'h11};
        req = 2'b11;
        tick(1);
        check("cont_first", gnt, 2'b01);
        tick(1);
        finish_busy("cont1", 2'b01);
        tick(1);
        check("cont_second", gnt, 2'b10);
        check("cont_second_dev", bus.dev_add, 7'h22);
        tick(1);
        finish_busy("cont2", 2'b10);
        tick(1);
        check("cont_third", gnt, 2'b01);
        tick(1);
        finish_busy("cont3", 2'b01);
        req = 2'b00;
        tick(1);
        req = 2'b11;
        tick(1);
        check("cont_repeat", gnt, 2'b10);
        tick(1);
        finish_busy("cont4", 2'b10);
        req = 2'b00;

        // No grant while ready is low
        bus.ready = 1'b0; req = 2'b01;
        tick(3);
        check("rdy_block_gnt", gnt, 2'b00);
        check("rdy_block_busy", busy, 1'b0);
        bus.ready = 1'b1;
        tick(1);
        check("rdy_gnt", gnt, 2'b01);
        tick(1);
        finish_busy("rdy", 2'b01);
        req = 2'b00;

        // Reads from requester 0 then requester 1
        req_rw = 2'b01; req = 2'b01;
        tick(1);
        check("rd0_rw", bus.rw, 1'b1);
        tick(1);
        req = 2'b00;
        bus.drd_lcdData = 8'h1A; bus.ack_e = 1'b1;
        #1 check("rd0_back", byte_ack, 2'b01);
        tick(1);
        bus.ack_e = 1'b0; bus.drd_lcdData = 8'h33;
        #1 check("rd0_back_low", byte_ack, 2'b00);
        check("rd0_rdata", rdata, 8'h1A);
        finish_busy("rd0", 2'b01);
        req_rw = 2'b10; req_nbyte[11:6] = 6'd4; req = 2'b10;
        tick(2);
        req = 2'b00;
        bus.drd_lcdData = 8'hC3; bus.ack_e = 1'b1;
        #1 check("rd1_back", byte_ack, 2'b10);
        tick(1);
        bus.ack_e = 1'b0;
        check("rd1_rdata", rdata, 8'hC3);
        finish_busy("rd1", 2'b10);
        req_rw = 2'b00;

        // Zero byte count: no go, error pulse
        snap_go = go_cnt;
        req_nbyte[5:0] = 6'd0; req = 2'b01;
        tick(1);
        check("nb0_go", bus.go, 1'b0);
        check("nb0_gnt", gnt, 2'b01);
        tick(1);
        check("nb0_err", err, 2'b01);
        check("nb0_cmp", cmp, 2'b00);
        req = 2'b00;
        tick(1);
        check("nb0_err_end", err, 2'b00);
        check("nb0_busy", busy, 1'b0);
        check("nb0_go_count", go_cnt, snap_go);

        // Watchdog expiry on the 16-cycle instance
        do_reset();
        req_nbyte[5:0] = 6'd3; req = 2'b01;
        tick(2);
        req = 2'b00;
        tick(15);
        check("to_early_err", err16, 2'b00);
        check("to_early_busy", busy16, 1'b1);
        tick(1);
        check("to_err", err16, 2'b01);
        check("to_cmp", cmp16, 2'b00);
        tick(1);
        check("to_busy_low", busy16, 1'b0);
        check("to_gnt_low", gnt16, 2'b00);

        // done on the watchdog's final cycle wins
        req = 2'b01;
        tick(2);
        req = 2'b00;
        tick(15);
        bus.done = 1'b1;
        tick(1);
        check("tie_cmp", cmp16, 2'b01);
        check("tie_err", err16, 2'b00);
        bus.done = 1'b0;
        tick(1);

        // Reset while BUSY
        do_reset();
        snap_cmp = cmp_cnt; snap_err = err_cnt;
        req_nbyte[5:0] = 6'd2; req_dev[6:0] = 7'h48; req = 2'b01;
        tick(2);
        bus.ack_e = 1'b1;
        #1 check("rb_busy_pre", busy, 1'b1);
        reset = 1'b1;
        tick(1);
        check("rb_gnt", gnt, 2'b00);
        check("rb_busy", busy, 1'b0);
        check("rb_go", bus.go, 1'b0);
        check("rb_back", byte_ack, 2'b00);
        check("rb_nbyte", bus.N_Byte, 6'd0);
        check("rb_dev", bus.dev_add, 7'h00);
        reset = 1'b0; bus.ack_e = 1'b0; req = 2'b00;
        tick(2);
        check("rb_no_cmp", cmp_cnt, snap_cmp);
        check("rb_no_err", err_cnt, snap_err);
        check("cmp_err_exclusive", both_seen, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
